kernel_line_buffer: RTL and testbench
=====================================

KERNEL_LINE_BUFFER -- requirements
Module: kernel_line_buffer

Interface
REQ-001 Parameter HRES, default 240: pixels per line; storage depth per line bank.
REQ-002 Parameter VRES, default 320: lines per frame; used for vcount wrap.
REQ-003 Parameter NUM_LINES, default 3: vertical taps per output column, range 1..7.
REQ-004 Parameter PIXEL_WIDTH, default 8: bits per pixel.
REQ-005 Port clk_in, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-006 Port rst_in, input, 1: reset, asynchronous, active-low.
REQ-007 Port hcount_in, input, 11: column of the incoming pixel.
REQ-008 Port vcount_in, input, 10: row of the incoming pixel.
REQ-009 Port pixel_data_in, input, PIXEL_WIDTH: incoming pixel.
REQ-010 Port data_valid_in, input, 1: single-cycle qualifier for the three inputs above.
REQ-011 Port line_buffer_out, output, NUM_LINES*PIXEL_WIDTH: pixel column; lane k occupies bits [(k+1)*PIXEL_WIDTH-1 : k*PIXEL_WIDTH]; lane 0 is the oldest row.
REQ-012 Port hcount_out, output, 11: column of the emitted column.
REQ-013 Port vcount_out, output, 10: row of the centre lane.
REQ-014 Port data_valid_out, output, 1: single-cycle qualifier for the outputs.

Function
REQ-015 Storage SHALL be NUM_LINES+1 inferred RAM banks of HRES x PIXEL_WIDTH, each with one registered read port.
REQ-016 A write-bank pointer wr_sel (0..NUM_LINES) SHALL select the bank written; an accepted pixel SHALL be written to wr_sel at address hcount_in.
REQ-017 An input is accepted only when data_valid_in=1 and hcount_in<HRES; otherwise there is no write, no read and no output valid.
REQ-018 On an accepted pixel, the other NUM_LINES banks SHALL be read at hcount_in, ordered oldest to newest into lanes 0..NUM_LINES-1.
REQ-019 wr_sel SHALL advance on an accepted pixel with hcount_in=HRES-1, wrapping from NUM_LINES to 0; it does not advance otherwise.
REQ-020 Latency SHALL be exactly 2 cycles: an accepted pixel at cycle t gives data_valid_out=1 at t+2, with no bubbles added or removed.
REQ-021 hcount_out at t+2 SHALL equal hcount_in at t.
REQ-022 Define OFFSET=NUM_LINES-NUM_LINES/2 (integer division). vcount_out SHALL be vcount_in-OFFSET when vcount_in>=OFFSET, else vcount_in+VRES-OFFSET.
REQ-023 Back-to-back valids SHALL be sustained at one per cycle.
REQ-024 Read-during-write on the same address is not possible, because the written bank is never read.
REQ-025 Out-of-range valid input: data_valid_out is 0 two cycles later; the data outputs hold their previous values.

Reset
REQ-026 When rst_in=0, SHALL immediately force wr_sel=0, line_buffer_out=0, hcount_out=0, vcount_out=0, data_valid_out=0, and clear all pipeline valids.
REQ-027 RAM contents SHALL NOT be cleared by reset.
REQ-028 A pixel in flight when reset asserts mid-line SHALL be discarded; after release, the next accepted pixel is written to bank 0.

Configuration
REQ-029 Macro KERNEL_LINE_BUFFER_ZERO_EDGE_EN.
 - Defined: lane k SHALL output 0 when the vcount_in of the accepted pixel is < NUM_LINES-k, i.e. its source row precedes the frame top.
 - Undefined: lanes output raw bank contents, including stale rows from the previous frame.

Verification
Bench configuration: HRES=4, VRES=6, NUM_LINES=3, PIXEL_WIDTH=8; pixel value = 16*row+col; continuous valid.

REQ-030 Fill rows 0-2, then input row 3 col 1 -> 2 cycles later data_valid_out=1, hcount_out=1, vcount_out=1, lanes {0x01,0x11,0x21}.
REQ-031 data_valid_in=1 with hcount_in=4 -> no RAM write, data_valid_out=0 at t+2, wr_sel unchanged.
REQ-032 Frame 2 row 0 col 3 input -> vcount_out=4, hcount_out=3, lanes {0x33,0x43,0x53}; wr_sel wraps 3->0 at the correct line ends.
REQ-033 rst_in driven low at row 2 col 2 -> all outputs 0 in the same cycle, no valid emitted; after release, row 0 refill reproduces REQ-030.
REQ-034 Frame 2 row 1 col 2 input:
 - with the macro -> lanes {0x00,0x00,0x02};
 - without the macro -> lanes {0x42,0x52,0x02}.
REQ-035 Valid asserted every other cycle across row 3 -> outputs appear at the same 1-of-2 rate, each exactly 2 cycles after its input, with no extra valids.

Source files
------------

// File: rtl/kernel_line_buffer.sv
//------------------------------------------------------------------------------
// Module   : kernel_line_buffer
// Purpose  : Multi-line pixel buffer for sliding-window kernels. Each accepted
//            pixel is written into one of NUM_LINES+1 line banks. The other
//            NUM_LINES banks are read at the same column, which produces a
//            vertical column of NUM_LINES pixels (oldest row in lane 0). The
//            column appears two cycles later.
// Revision : 1.0 - initial release
//
// Ports
//   clk_in          in   1                       single clock, rising edge
//   rst_in          in   1                       async reset, active low
//   hcount_in       in   11                      column of incoming pixel
//   vcount_in       in   10                      row of incoming pixel
//   pixel_data_in   in   PIXEL_WIDTH             incoming pixel
//   data_valid_in   in   1                       qualifier for the inputs
//   line_buffer_out out  NUM_LINES*PIXEL_WIDTH   pixel column, lane 0 = oldest
//   hcount_out      out  11                      column of emitted column
//   vcount_out      out  10                      row of the centre lane
//   data_valid_out  out  1                       qualifier for the outputs
//
// Build option
//   KERNEL_LINE_BUFFER_ZERO_EDGE_EN : when defined, a lane whose source row
//   lies above the top of the frame is output as zero. Without it, that lane
//   shows stale data from the previous frame.
//------------------------------------------------------------------------------
`default_nettype none

module kernel_line_buffer #(
  parameter int HRES        = 240,
  parameter int VRES        = 320,
  parameter int NUM_LINES   = 3,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [10:0]                      hcount_in,
  input  logic [9:0]                       vcount_in,
  input  logic [PIXEL_WIDTH-1:0]           pixel_data_in,
  input  logic                             data_valid_in,
  output logic [NUM_LINES*PIXEL_WIDTH-1:0] line_buffer_out,
  output logic [10:0]                      hcount_out,
  output logic [9:0]                       vcount_out,
  output logic                             data_valid_out
);

  localparam int NUM_BANKS = NUM_LINES + 1;
  localparam int SEL_W     = $clog2(NUM_BANKS);
  localparam int ADDR_W    = (HRES > 1) ? $clog2(HRES) : 1;
  // Row distance from the incoming pixel to the centre lane.
  localparam int OFFSET    = NUM_LINES - NUM_LINES / 2;

  localparam logic [11:0]      HRES_EXT    = 12'(HRES);
  localparam logic [10:0]      HCOUNT_LAST = 11'(HRES - 1);
  localparam logic [9:0]       OFFSET_V    = 10'(OFFSET);
  localparam logic [9:0]       WRAP_ADD    = 10'(VRES - OFFSET);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_LINES);

  logic              accept;
  logic              line_end;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  wr_sel;

  assign accept   = data_valid_in && ({1'b0, hcount_in} < HRES_EXT);
  assign line_end = accept && (hcount_in == HCOUNT_LAST);
  assign addr     = hcount_in[ADDR_W-1:0];

  // Bank being filled. It rotates one step at the end of every line, so the
  // other banks always hold the previous NUM_LINES lines.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_sel <= '0;
    end else if (line_end) begin
      wr_sel <= (wr_sel == SEL_LAST) ? '0 : wr_sel + 1'b1;
    end
  end

  //--------------------------------------------------------------------------
  // Line banks: one write port and one registered read port each. The bank
  // being written is never read, so no read-during-write case exists.
  // Neither the contents nor the read register are reset.
  //--------------------------------------------------------------------------
  logic [PIXEL_WIDTH-1:0] rd_data [NUM_BANKS];

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [PIXEL_WIDTH-1:0] mem [HRES];
      logic [PIXEL_WIDTH-1:0] rd_q;
      logic                   is_wr;

      assign is_wr = (wr_sel == SEL_W'(b));

      always_ff @(posedge clk_in) begin
        if (accept && is_wr) begin
          mem[addr] <= pixel_data_in;
        end
        if (accept && !is_wr) begin
          rd_q <= mem[addr];
        end
      end

      assign rd_data[b] = rd_q;
    end
  endgenerate

  //--------------------------------------------------------------------------
  // Stage 1: sideband that travels alongside the RAM read
  //--------------------------------------------------------------------------
  logic [9:0] vcount_adj;

  // Centre-lane row. Rows near the top of the frame wrap into the previous frame.
  assign vcount_adj = (vcount_in >= OFFSET_V) ? (vcount_in - OFFSET_V)
                                              : (vcount_in + WRAP_ADD);

  logic             s1_valid;
  logic [10:0]      s1_hcount;
  logic [9:0]       s1_vcount;
  logic [SEL_W-1:0] s1_sel;

`ifdef KERNEL_LINE_BUFFER_ZERO_EDGE_EN
  // Lane k reads the row NUM_LINES-k above the incoming row. That row does
  // not exist yet in this frame when vcount_in < NUM_LINES-k.
  logic [NUM_LINES-1:0] zero_next;
  logic [NUM_LINES-1:0] s1_zero;

  always_comb begin
    zero_next = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      zero_next[k] = (int'(vcount_in) < (NUM_LINES - k));
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid  <= 1'b0;
      s1_hcount <= '0;
      s1_vcount <= '0;
      s1_sel    <= '0;
`ifdef KERNEL_LINE_BUFFER_ZERO_EDGE_EN
      s1_zero   <= '0;
`endif
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_hcount <= hcount_in;
        s1_vcount <= vcount_adj;
        s1_sel    <= wr_sel;
`ifdef KERNEL_LINE_BUFFER_ZERO_EDGE_EN
        s1_zero   <= zero_next;
`endif
      end
    end
  end

  //--------------------------------------------------------------------------
  // Lane ordering: the oldest line sits in the bank just after the one that
  // was being written. Lane k uses bank (sel + 1 + k) mod NUM_BANKS.
  //--------------------------------------------------------------------------
  logic [NUM_LINES*PIXEL_WIDTH-1:0] lanes_next;
  int                               lane_src;

  always_comb begin
    lanes_next = '0;
    lane_src   = 0;
    for (int k = 0; k < NUM_LINES; k++) begin
      lane_src = int'(s1_sel) + 1 + k;
      if (lane_src >= NUM_BANKS) begin
        lane_src = lane_src - NUM_BANKS;
      end
      lanes_next[k*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_data[SEL_W'(lane_src)];
`ifdef KERNEL_LINE_BUFFER_ZERO_EDGE_EN
      if (s1_zero[k]) begin
        lanes_next[k*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
      end
`endif
    end
  end

  //--------------------------------------------------------------------------
  // Stage 2: output registers. The data outputs keep their values when no
  // column is emitted.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      line_buffer_out <= '0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      data_valid_out  <= 1'b0;
    end else begin
      data_valid_out <= s1_valid;
      if (s1_valid) begin
        line_buffer_out <= lanes_next;
        hcount_out      <= s1_hcount;
        vcount_out      <= s1_vcount;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kernel_line_buffer.sv
//------------------------------------------------------------------------------
// Module   : tb_kernel_line_buffer
// Purpose  : Self-checking bench for kernel_line_buffer (HRES=4, VRES=6,
//            NUM_LINES=3, PIXEL_WIDTH=8). The reference model records the
//            history of every written line. Each column is predicted from
//            the NUM_LINES lines written before the current one.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_kernel_line_buffer;

  localparam int HRES   = 4;
  localparam int VRES   = 6;
  localparam int NL     = 3;
  localparam int PW     = 8;
  localparam int OFFSET = NL - NL / 2;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic [PW-1:0]     pixel_data_in;
  logic              data_valid_in;
  logic [NL*PW-1:0]  line_buffer_out;
  logic [10:0]       hcount_out;
  logic [9:0]        vcount_out;
  logic              data_valid_out;

  always #5 clk_in = ~clk_in;

  kernel_line_buffer #(
    .HRES        (HRES),
    .VRES        (VRES),
    .NUM_LINES   (NL),
    .PIXEL_WIDTH (PW)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .pixel_data_in   (pixel_data_in),
    .data_valid_in   (data_valid_in),
    .line_buffer_out (line_buffer_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .data_valid_out  (data_valid_out)
  );

  typedef struct {
    bit              valid;
    int              h;
    int              v;
    logic [NL*PW-1:0] lanes;
    bit   [NL-1:0]   known;
  } exp_t;

  exp_t pend;            // column for the pixel accepted at the last edge
  exp_t held;            // what the outputs should show right now
  int   hist [int];      // pixel history, key = line*HRES + column
  int   cur_line = 0;    // absolute index of the line being filled
  int   compared = 0;
  int   mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("data_valid_out", 32'(data_valid_out), 32'(held.valid));
    check("hcount_out", 32'(hcount_out), 32'(held.h));
    check("vcount_out", 32'(vcount_out), 32'(held.v));
    for (int k = 0; k < NL; k++) begin
      if (held.known[k]) begin
        check($sformatf("lane%0d", k), 32'(line_buffer_out[k*PW +: PW]),
              32'(held.lanes[k*PW +: PW]));
      end
    end
  endtask

  // Storage holds NL+1 lines. After reset, filling restarts at the first
  // storage slot, so the line index moves to the next multiple of NL+1.
  task automatic model_reset();
    pend.valid  = 1'b0;
    held.valid  = 1'b0;
    held.h      = 0;
    held.v      = 0;
    held.lanes  = '0;
    held.known  = '1;
    cur_line    = ((cur_line + NL) / (NL + 1)) * (NL + 1);
  endtask

  // One clock cycle. Drive the inputs, advance the model, then check the outputs.
  task automatic cyc(input bit v, input int h, input int r, input int p);
    int src;
    data_valid_in = v;
    hcount_in     = 11'(h);
    vcount_in     = 10'(r);
    pixel_data_in = 8'(p);
    @(posedge clk_in);
    #1;
    if (pend.valid) held = pend;
    else            held.valid = 1'b0;
    pend.valid = 1'b0;
    if (v && h < HRES) begin
      hist[cur_line*HRES + h] = p;
      pend.valid = 1'b1;
      pend.h     = h;
      pend.v     = (r + VRES - OFFSET) % VRES;
      pend.lanes = '0;
      pend.known = '0;
      for (int k = 0; k < NL; k++) begin
        src = cur_line - NL + k;
`ifdef KERNEL_LINE_BUFFER_ZERO_EDGE_EN
        if (r < NL - k) begin
          pend.known[k] = 1'b1;
          continue;
        end
`endif
        if (src >= 0 && hist.exists(src*HRES + h)) begin
          pend.lanes[k*PW +: PW] = 8'(hist[src*HRES + h]);
          pend.known[k]          = 1'b1;
        end
      end
      if (h == HRES - 1) cur_line++;
    end
    check_outputs();
  endtask

  task automatic send_row(input int r);
    for (int c = 0; c < HRES; c++) cyc(1'b1, c, r, 16*r + c);
  endtask

  initial begin
    rst_in        = 1'b0;
    data_valid_in = 1'b0;
    hcount_in     = '0;
    vcount_in     = '0;
    pixel_data_in = '0;
    model_reset();
    #2;
    check_outputs();
    repeat (2) cyc(1'b0, 0, 0, 0);
    rst_in = 1'b1;

    // Frame 1
    send_row(0);
    send_row(1);
    send_row(2);
    // Out-of-range column: no write, and no output valid two cycles later
    cyc(1'b1, 4, 2, 8'hEE);
    cyc(1'b0, 0, 0, 0);
    check("oob_no_valid", 32'(data_valid_out), 32'd0);
    // Row 3 with valid on every other cycle
    for (int c = 0; c < HRES; c++) begin
      cyc(1'b1, c, 3, 48 + c);
      check("alt_idle_valid", 32'(data_valid_out), 32'd0);
      cyc(1'b0, 0, 0, 0);
      check("alt_valid", 32'(data_valid_out), 32'd1);
      check("alt_hcount", 32'(hcount_out), 32'(c));
      if (c == 1) begin
        check("r3c1_vcount", 32'(vcount_out), 32'd1);
        check("r3c1_lanes", 32'(line_buffer_out), 32'h211101);
      end
    end
    send_row(4);
    send_row(5);

    // Frame 2
    send_row(0);
    cyc(1'b1, 0, 1, 16);
    check("f2r0c3_valid", 32'(data_valid_out), 32'd1);
    check("f2r0c3_hcount", 32'(hcount_out), 32'd3);
    check("f2r0c3_vcount", 32'(vcount_out), 32'd4);
    check("f2r0c3_lanes", 32'(line_buffer_out), 32'h534333);
    cyc(1'b1, 1, 1, 17);
    cyc(1'b1, 2, 1, 18);
    cyc(1'b1, 3, 1, 19);
    check("f2r1c2_hcount", 32'(hcount_out), 32'd2);
    check("f2r1c2_vcount", 32'(vcount_out), 32'd5);
`ifdef KERNEL_LINE_BUFFER_ZERO_EDGE_EN
    check("f2r1c2_lanes", 32'(line_buffer_out), 32'h020000);
`else
    check("f2r1c2_lanes", 32'(line_buffer_out), 32'h025242);
`endif

    // Reset in the middle of row 2 while a pixel is still in the pipeline
    cyc(1'b1, 0, 2, 32);
    cyc(1'b1, 1, 2, 33);
    cyc(1'b1, 2, 2, 34);
    rst_in = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_lanes", 32'(line_buffer_out), 32'd0);
    cyc(1'b0, 0, 0, 0);
    cyc(1'b0, 0, 0, 0);
    check("rst_no_valid", 32'(data_valid_out), 32'd0);
    rst_in = 1'b1;

    // Refill after reset
    send_row(0);
    send_row(1);
    send_row(2);
    cyc(1'b1, 0, 3, 48);
    cyc(1'b1, 1, 3, 49);
    cyc(1'b1, 2, 3, 50);
    check("post_rst_valid", 32'(data_valid_out), 32'd1);
    check("post_rst_hcount", 32'(hcount_out), 32'd1);
    check("post_rst_vcount", 32'(vcount_out), 32'd1);
    check("post_rst_lanes", 32'(line_buffer_out), 32'h211101);
    cyc(1'b1, 3, 3, 51);
    send_row(4);
    send_row(5);

    // Randomized frames: random data, idle gaps and out-of-range columns
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < VRES; r++) begin
        for (int c = 0; c < HRES; c++) begin
          repeat ($urandom_range(0, 2)) begin
            cyc(1'b0, int'($urandom_range(0, 2047)), r, int'($urandom_range(0, 255)));
          end
          if ($urandom_range(0, 7) == 0) begin
            cyc(1'b1, int'($urandom_range(HRES, 2047)), r, int'($urandom_range(0, 255)));
          end
          cyc(1'b1, c, r, int'($urandom_range(0, 255)));
        end
      end
    end
    repeat (3) cyc(1'b0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
